accel_host_ctrl: RTL and testbench
==================================

# accel_host_ctrl

Synthesizable host-side controller for a Bambu-generated accelerator top, driving the side the simulation bench leaves tied off. It pulses `start_port`, counts cycles until `done_port`, and reports the count with a timeout flag. While the accelerator is idle, it acts as initiator on the accelerator's slave memory port (`S_oe_ram`/`S_we_ram`/`S_addr_ram`/`S_Wdata_ram`/`S_data_ram_size` → `Sout_Rdata_ram`/`Sout_DataRdy`) to preload inputs and read back results.

## Interface
Parameters:
- `CHANNELS`, 2: slave-port lanes; only lane 0 is driven, others are held 0.
- `ADDR_W`, 8: address bits per lane.
- `DATA_W`, 64: data bits per lane.
- `SIZE_W`, 7: access-size bits per lane; the value is a size in bits (8/16/32/64).
- `MAX_CYCLES`, 200000000: run timeout in cycles.
- `MEM_TIMEOUT`, 1024: cycles to wait for `Sout_DataRdy`.

Ports (clock and reset):
- `clock`  in  1  — single clock; all logic on posedge.
- `reset`  in  1  — asynchronous, active-low.

Host side:
- `run_req`  in  1  — single-cycle pulse requesting one accelerator run.
- `cmd_valid`  in  1  — memory command offered.
- `cmd_ready`  out  1  — command accepted when high together with `cmd_valid`.
- `cmd_we`  in  1  — 1 = write, 0 = read.
- `cmd_addr`  in  `ADDR_W`  — memory address.
- `cmd_wdata`  in  `DATA_W`  — write data.
- `cmd_size`  in  `SIZE_W`  — access size.
- `rsp_valid`  out  1  — one-cycle pulse; command finished.
- `rsp_rdata`  out  `DATA_W`  — read data; 0 for writes.
- `rsp_err`  out  1  — qualifies `rsp_valid`: memory timeout.
- `run_done`  out  1  — one-cycle pulse; run finished.
- `run_timeout`  out  1  — qualifies `run_done`.
- `cycle_count`  out  32  — cycles of the last run; held until the next run completes.
- `busy`  out  1  — any state other than IDLE.

Accelerator side:
- `start_port`  out  1
- `done_port`  in  1
- `S_oe_ram`  out  `CHANNELS`
- `S_we_ram`  out  `CHANNELS`
- `S_addr_ram`  out  `CHANNELS*ADDR_W`
- `S_Wdata_ram`  out  `CHANNELS*DATA_W`
- `S_data_ram_size`  out  `CHANNELS*SIZE_W`
- `Sout_Rdata_ram`  in  `CHANNELS*DATA_W`
- `Sout_DataRdy`  in  `CHANNELS`

## Operation
State machine:
- **IDLE**: `cmd_ready = !run_req`.
  - `run_req` → START. `run_req` has priority over a same-cycle `cmd_valid`; that command is not accepted.
  - Accepted command → MEM: latch `we`/`addr`/`wdata`/`size`, and clear the wait counter.
- **MEM**: drive lane 0 every cycle. `S_oe_ram[0] = !we`, `S_we_ram[0] = we`; address, data and size come from the latched fields.
  - `Sout_DataRdy[0]` → RSP, capturing `Sout_Rdata_ram[DATA_W-1:0]` (reads) or 0 (writes).
  - Wait counter reaching `MEM_TIMEOUT` → RSP with error set and data 0.
- **RSP**: `rsp_valid = 1` for one cycle; slave outputs return to 0; → IDLE.
- **START**: `start_port = 1` for exactly one cycle; run counter = 1 → WAIT.
- **WAIT**: run counter increments each cycle.
  - `done_port` high → END, `cycle_count` = counter value in that cycle.
  - Counter == `MAX_CYCLES` → END with timeout.
- **END**: `run_done = 1` for one cycle; `run_timeout` = timeout flag; → IDLE.

Rules:
- `done_port` outside WAIT is ignored.
- `run_req` outside IDLE is dropped. `cmd_valid` outside IDLE is stalled (`cmd_ready = 0`).
- Counters saturate at their limits; there is no wrap.
- Slave outputs are 0 in all states except MEM.

## Timing
- Reset value of every output is 0, including `cycle_count` and `busy`. Asserting reset mid-run or mid-access returns to IDLE immediately with all outputs 0; no response or done pulse is produced.
- Run latency: `run_req` at cycle t → `start_port` at t+1 → `done_port` seen at cycle d → `run_done` at d+1. `cycle_count = d - t`: a done one cycle after start reports 2.
- Memory latency: command accepted at t → lane driven from t+1 → `Sout_DataRdy` at r → `rsp_valid` at r+1.
- Back-to-back commands: the next command can be accepted in the cycle after `rsp_valid`. Throughput is at most one command per (rdy latency + 2) cycles.
- `rsp_rdata` is stable only while `rsp_valid` is high.

## Structure
- Package `accel_host_pkg`:
  - state enum (IDLE, MEM, RSP, START, WAIT, END);
  - lane-slice helper constants;
  - the 32-bit count width.
- One sub-module, `sat_cycle_counter`: load-1 / increment / saturate at a limit, with a `hit` output. It is instantiated twice, once for the run count and once for the memory wait.

## Test plan
- Reset asserted asynchronously mid-WAIT → all outputs 0 in the same cycle; `run_req` after release starts a fresh run.
- `run_req`, accelerator model raises `done_port` 10 cycles after `start_port` → one `start_port` pulse, `run_done`=1, `run_timeout`=0, `cycle_count`=11.
- Write addr 0x10, data 0x0000_0000_DEAD_BEEF, size 32, slave replies after 2 cycles → `S_we_ram`=2'b01 for 3 cycles, `rsp_valid` with `rsp_rdata`=0, `rsp_err`=0; then read 0x10 → `rsp_rdata`=0xDEADBEEF.
- `run_req` and `cmd_valid` asserted in the same IDLE cycle → `cmd_ready`=0, run starts; the command is accepted only after `run_done`.
- With `MAX_CYCLES`=50 and no `done_port` → `run_done` with `run_timeout`=1, `cycle_count`=50. With `MEM_TIMEOUT`=8 and no `Sout_DataRdy` → `rsp_err`=1.
- `done_port` pulsed while in IDLE → no `run_done`, `cycle_count` unchanged.

Source files
------------

// File: rtl/accel_host_pkg.sv
// Shared types and constants for the accelerator host controller.
package accel_host_pkg;

   localparam int CNT_W = 32;
   localparam int LANE0 = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MEM,
      ST_RSP,
      ST_START,
      ST_WAIT,
      ST_END
   } state_t;

   // Low bit of a lane inside a flattened per-lane bus.
   function automatic int lane_lo(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/accel_host_ctrl_sat_cycle_counter.sv
// Cycle counter: load to 1, increment while enabled, hold at the limit.
module sat_cycle_counter #(
   parameter int W = 32
) (
   input  logic         i_clock,
   input  logic         i_reset_n,
   input  logic         i_load,
   input  logic         i_inc,
   input  logic [W-1:0] i_limit,
   output logic [W-1:0] o_count,
   output logic         o_hit
);

   logic [W-1:0] r_count;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n)
         r_count <= '0;
      else if (i_load)
         r_count <= W'(1);
      else if (i_inc && (r_count < i_limit))
         r_count <= r_count + W'(1);
   end

   assign o_count = r_count;
   assign o_hit   = (r_count == i_limit);

endmodule

// File: rtl/accel_host_ctrl.sv
// Host-side controller for a Bambu accelerator: run start/timing and
// single-lane access to the accelerator's slave memory port.
module accel_host_ctrl
   import accel_host_pkg::*;
#(
   parameter int CHANNELS    = 2,
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 64,
   parameter int SIZE_W      = 7,
   parameter int MAX_CYCLES  = 200000000,
   parameter int MEM_TIMEOUT = 1024
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       run_req,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       cmd_we,
   input  logic [ADDR_W-1:0]          cmd_addr,
   input  logic [DATA_W-1:0]          cmd_wdata,
   input  logic [SIZE_W-1:0]          cmd_size,
   output logic                       rsp_valid,
   output logic [DATA_W-1:0]          rsp_rdata,
   output logic                       rsp_err,
   output logic                       run_done,
   output logic                       run_timeout,
   output logic [31:0]                cycle_count,
   output logic                       busy,
   output logic                       start_port,
   input  logic                       done_port,
   output logic [CHANNELS-1:0]        S_oe_ram,
   output logic [CHANNELS-1:0]        S_we_ram,
   output logic [CHANNELS*ADDR_W-1:0] S_addr_ram,
   output logic [CHANNELS*DATA_W-1:0] S_Wdata_ram,
   output logic [CHANNELS*SIZE_W-1:0] S_data_ram_size,
   input  logic [CHANNELS*DATA_W-1:0] Sout_Rdata_ram,
   input  logic [CHANNELS-1:0]        Sout_DataRdy
);

   localparam int A_LO = lane_lo(LANE0, ADDR_W);
   localparam int D_LO = lane_lo(LANE0, DATA_W);
   localparam int S_LO = lane_lo(LANE0, SIZE_W);

   state_t              r_state, w_next;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [SIZE_W-1:0]   r_size;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_err;
   logic                r_timeout;
   logic [CNT_W-1:0]    r_cycle_count;

   logic [CNT_W-1:0]    w_run_cnt;
   logic [CNT_W-1:0]    w_wait_cnt;
   logic                w_run_hit;
   logic                w_wait_hit;
   logic                w_accept;
   logic                w_rdy;
   logic                w_run_end;
   logic                w_unused;

   assign w_rdy     = Sout_DataRdy[LANE0];
   assign w_accept  = (r_state == ST_IDLE) && cmd_valid && !run_req;
   assign w_run_end = (r_state == ST_WAIT) && (done_port || w_run_hit);
   // Other lanes and the raw wait count are intentionally unobserved.
   assign w_unused  = ^{Sout_Rdata_ram, Sout_DataRdy, w_wait_cnt};

   // Run count is 1 while start_port is high, so done seen at cycle d reports d - t.
   sat_cycle_counter #(.W(CNT_W)) u_run_cnt (
      .i_clock   (clock),
      .i_reset_n (reset),
      .i_load    ((r_state == ST_IDLE) && run_req),
      .i_inc     ((r_state == ST_START) || (r_state == ST_WAIT)),
      .i_limit   (CNT_W'(MAX_CYCLES)),
      .o_count   (w_run_cnt),
      .o_hit     (w_run_hit)
   );

   sat_cycle_counter #(.W(CNT_W)) u_wait_cnt (
      .i_clock   (clock),
      .i_reset_n (reset),
      .i_load    (w_accept),
      .i_inc     (r_state == ST_MEM),
      .i_limit   (CNT_W'(MEM_TIMEOUT)),
      .o_count   (w_wait_cnt),
      .o_hit     (w_wait_hit)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (run_req) w_next = ST_START;
                   else if (cmd_valid) w_next = ST_MEM;
         ST_MEM:   if (w_rdy || w_wait_hit) w_next = ST_RSP;
         ST_RSP:   w_next = ST_IDLE;
         ST_START: w_next = ST_WAIT;
         ST_WAIT:  if (done_port || w_run_hit) w_next = ST_END;
         ST_END:   w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_we          <= 1'b0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_size        <= '0;
         r_rdata       <= '0;
         r_err         <= 1'b0;
         r_timeout     <= 1'b0;
         r_cycle_count <= '0;
      end else begin
         if (w_accept) begin
            r_we    <= cmd_we;
            r_addr  <= cmd_addr;
            r_wdata <= cmd_wdata;
            r_size  <= cmd_size;
            r_err   <= 1'b0;
         end
         // A ready reply wins over a timeout landing in the same cycle.
         if (r_state == ST_MEM) begin
            if (w_rdy) begin
               r_rdata <= r_we ? '0 : Sout_Rdata_ram[D_LO +: DATA_W];
               r_err   <= 1'b0;
            end else if (w_wait_hit) begin
               r_rdata <= '0;
               r_err   <= 1'b1;
            end
         end
         if (w_run_end) begin
            r_cycle_count <= w_run_cnt;
            r_timeout     <= !done_port;
         end
      end
   end

   always_comb begin
      S_oe_ram        = '0;
      S_we_ram        = '0;
      S_addr_ram      = '0;
      S_Wdata_ram     = '0;
      S_data_ram_size = '0;
      if (r_state == ST_MEM) begin
         S_oe_ram[LANE0]                 = !r_we;
         S_we_ram[LANE0]                 = r_we;
         S_addr_ram[A_LO +: ADDR_W]      = r_addr;
         S_Wdata_ram[D_LO +: DATA_W]     = r_wdata;
         S_data_ram_size[S_LO +: SIZE_W] = r_size;
      end
   end

   // cmd_ready is gated by reset so every output reads 0 while it is held.
   assign cmd_ready   = reset && (r_state == ST_IDLE) && !run_req;
   assign rsp_valid   = (r_state == ST_RSP);
   assign rsp_rdata   = r_rdata;
   assign rsp_err     = (r_state == ST_RSP) && r_err;
   assign run_done    = (r_state == ST_END);
   assign run_timeout = (r_state == ST_END) && r_timeout;
   assign cycle_count = r_cycle_count;
   assign busy        = (r_state != ST_IDLE);
   assign start_port  = (r_state == ST_START);

endmodule

// File: tb/tb_accel_host_ctrl.sv
// Directed bench for accel_host_ctrl with a small accelerator/slave-port model.
module tb_accel_host_ctrl;

   logic          clock, reset;
   logic          run_req, cmd_valid, cmd_ready, cmd_we;
   logic [7:0]    cmd_addr;
   logic [63:0]   cmd_wdata;
   logic [6:0]    cmd_size;
   logic          rsp_valid, rsp_err, run_done, run_timeout, busy, start_port, done_port;
   logic [63:0]   rsp_rdata;
   logic [31:0]   cycle_count;
   logic [1:0]    S_oe_ram, S_we_ram, Sout_DataRdy;
   logic [15:0]   S_addr_ram;
   logic [127:0]  S_Wdata_ram, Sout_Rdata_ram;
   logic [13:0]   S_data_ram_size;

   int n_chk, n_fail;
   logic          mem_en;
   logic          drv;
   int            mcnt;
   logic [63:0]   mem [256];
   int            dummy;

   accel_host_ctrl #(
      .CHANNELS(2), .ADDR_W(8), .DATA_W(64), .SIZE_W(7),
      .MAX_CYCLES(50), .MEM_TIMEOUT(8)
   ) dut (
      .clock(clock), .reset(reset), .run_req(run_req),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .run_done(run_done), .run_timeout(run_timeout), .cycle_count(cycle_count),
      .busy(busy), .start_port(start_port), .done_port(done_port),
      .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
      .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
      .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Slave replies in the third cycle its lane 0 is driven; lane 1 returns junk.
   assign drv            = S_oe_ram[0] | S_we_ram[0];
   assign Sout_DataRdy   = {1'b0, mem_en && drv && (mcnt == 2)};
   assign Sout_Rdata_ram = {64'hA5A5_A5A5_A5A5_A5A5, mem[S_addr_ram[7:0]]};

   always @(posedge clock) begin
      mcnt <= drv ? mcnt + 1 : 0;
      if (Sout_DataRdy[0] && S_we_ram[0]) mem[S_addr_ram[7:0]] <= S_Wdata_ram[63:0];
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic do_run(input int dly, input bit give_done, input bit with_cmd,
                         input logic [31:0] exp_cnt, input bit exp_to);
      int starts, acc;
      bit got, to;
      logic [31:0] cnt;
      starts = 0; acc = 0; got = 0; to = 0; cnt = 0;
      @(negedge clock);
      run_req = 1'b1; cmd_valid = with_cmd; #1;
      chk("run_req_blocks_cmd", cmd_ready, 0);
      for (int c = 1; c < 200 && !got; c++) begin
         @(negedge clock);
         run_req   = 1'b0;
         done_port = give_done && (c == dly + 1);
         #1;
         if (start_port) starts++;
         if (cmd_valid && cmd_ready) acc++;
         if (run_done) begin got = 1; to = run_timeout; cnt = cycle_count; end
      end
      done_port = 1'b0;
      chk("run_done_seen", got, 1);
      chk("start_pulses", starts, 1);
      chk("run_timeout", to, exp_to);
      chk("cycle_count", cnt, exp_cnt);
      if (cmd_valid) chk("run_stalls_cmd", acc, 0);
   endtask

   task automatic do_mem(input bit we, input logic [7:0] a, input logic [63:0] wd,
                         input logic [6:0] sz, input logic [63:0] exp_rd, input bit exp_err,
                         input int exp_drv, output int waits);
      int drv_n;
      bit got;
      logic [63:0] rd;
      logic er;
      logic [7:0] sa;
      logic [6:0] ss;
      drv_n = 0; got = 0; rd = 0; er = 0; sa = 0; ss = 0; waits = 0;
      @(negedge clock);
      cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = wd; cmd_size = sz; #1;
      while (!cmd_ready && waits < 20) begin @(negedge clock); #1; waits++; end
      chk("cmd_accepted", cmd_ready, 1);
      @(negedge clock);
      cmd_valid = 1'b0;
      for (int c = 0; c < 50 && !got; c++) begin
         #1;
         if (rsp_valid) begin
            got = 1; rd = rsp_rdata; er = rsp_err;
            chk("rsp_slave_idle", {S_oe_ram, S_we_ram, S_addr_ram}, 0);
         end else begin
            if (we ? (S_we_ram == 2'b01 && S_oe_ram == 2'b00)
                   : (S_oe_ram == 2'b01 && S_we_ram == 2'b00)) drv_n++;
            sa = S_addr_ram[7:0]; ss = S_data_ram_size[6:0];
            @(negedge clock);
         end
      end
      chk("rsp_seen", got, 1);
      chk("rsp_rdata", rd, exp_rd);
      chk("rsp_err", er, exp_err);
      chk("lane0_drive_cycles", drv_n, exp_drv);
      chk("lane0_addr", sa, a);
      chk("lane0_size", ss, sz);
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      reset = 1'b0; run_req = 0; cmd_valid = 0; cmd_we = 0; cmd_addr = 0;
      cmd_wdata = 0; cmd_size = 0; done_port = 0; mem_en = 1'b1; mcnt = 0;
      repeat (2) @(negedge clock);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_cycle_count", cycle_count, 0);
      chk("rst_outs", {start_port, run_done, rsp_valid, S_oe_ram, S_we_ram}, 0);
      @(negedge clock);
      reset = 1'b1;

      do_run(10, 1, 0, 32'd11, 0);

      do_mem(1, 8'h10, 64'h0000_0000_DEAD_BEEF, 7'd32, 64'h0, 0, 3, dummy);
      do_mem(0, 8'h10, 64'h0, 7'd32, 64'h0000_0000_DEAD_BEEF, 0, 3, dummy);

      // Command held alongside run_req: stalled for the whole run.
      cmd_we = 1'b1; cmd_addr = 8'h20; cmd_wdata = 64'h1234; cmd_size = 7'd16;
      do_run(3, 1, 1, 32'd4, 0);
      do_mem(1, 8'h20, 64'h1234, 7'd16, 64'h0, 0, 3, dummy);
      chk("cmd_after_run_done", dummy, 0);
      do_mem(0, 8'h20, 64'h0, 7'd64, 64'h1234, 0, 3, dummy);

      do_run(0, 0, 0, 32'd50, 1);

      begin
         int rd;
         rd = 0;
         @(negedge clock);
         done_port = 1'b1;
         for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            done_port = 1'b0;
            #1;
            if (run_done || busy) rd++;
         end
         chk("idle_done_ignored", rd, 0);
         chk("idle_done_count_kept", cycle_count, 50);
      end

      mem_en = 1'b0;
      do_mem(0, 8'h30, 64'h0, 7'd64, 64'h0, 1, 8, dummy);
      mem_en = 1'b1;

      @(negedge clock);
      run_req = 1'b1;
      @(negedge clock);
      run_req = 1'b0;
      repeat (4) @(negedge clock);
      #1;
      chk("wait_busy", busy, 1);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_count", cycle_count, 0);
      chk("arst_outs", {start_port, run_done, rsp_valid, cmd_ready}, 0);
      @(negedge clock);
      reset = 1'b1;
      do_run(3, 1, 0, 32'd4, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
